// File: rtl/i2s_tx_unit.sv
// I2S master transmitter: buffers stereo 24-bit frames from the DSP stage in a small
// FIFO and serialises them as SCK/WS/SDO, requesting one new sample per frame.
module i2s_tx_unit #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             play_in,
    input  logic             valid_in,
    input  logic [1:0][23:0] audio_in,
    output logic             tick_out,
    output logic             sck_out,
    output logic             ws_out,
    output logic             sdo_out,
    output logic             underrun_out
);

    localparam int unsigned SAMPLE_W = 24;
    localparam int unsigned SLOT_W   = 32;
    localparam int unsigned PAD_W    = SLOT_W - SAMPLE_W;
    localparam int unsigned FRAME_W  = 2 * SLOT_W;
    localparam int unsigned BIT_W    = 6;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] WS_FIRST = BIT_W'(SLOT_W - 1);
    localparam logic [BIT_W-1:0] WS_LAST  = BIT_W'(FRAME_W - 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [DIV_W-1:0]         div_q, div_d;
    logic [BIT_W-1:0]         bit_q, bit_d;
    logic [FRAME_W-1:0]       shift_q, shift_d;
    logic                     sck_d, ws_d, sdo_d, tick_d, underrun_d;

    logic [1:0][SAMPLE_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]         count_q;
    logic                     load, pop, push, push_ok, flush;

    // Sequencing, SCK/bit timing and frame loading; outputs precomputed for the next edge.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        sck_d      = sck_out;
        ws_d       = 1'b0;
        sdo_d      = 1'b0;
        tick_d     = 1'b0;
        underrun_d = 1'b0;
        load       = 1'b0;
        pop        = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                flush   = 1'b1;
                div_d   = '0;
                bit_d   = '0;
                shift_d = '0;
                sck_d   = 1'b0;
                if (play_in) begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                end
            end
            ST_RUN, ST_STOP: begin
                push = valid_in;
                if (state_q == ST_RUN && !play_in) begin
                    state_d = ST_STOP;
                end
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    sck_d = ~sck_out;
                    // SCK falling edge: advance the bit position
                    if (sck_out) begin
                        if (bit_q == BIT_LAST) begin
                            if (state_q == ST_STOP) begin
                                state_d = ST_IDLE;
                                flush   = 1'b1;
                                bit_d   = '0;
                                shift_d = '0;
                            end else begin
                                load = 1'b1;
                            end
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                flush   = 1'b1;
            end
        endcase

        // Frame boundary: pop the next frame or play silence on underrun
        if (load) begin
            pop        = (count_q != '0);
            tick_d     = 1'b1;
            underrun_d = ~pop;
            bit_d      = '0;
            if (pop) begin
                shift_d = {fifo_mem[rd_ptr_q][0], {PAD_W{1'b0}},
                           fifo_mem[rd_ptr_q][1], {PAD_W{1'b0}}};
            end else begin
                shift_d = '0;
            end
        end

        if (state_d == ST_IDLE) begin
            sck_d = 1'b0;
        end else begin
            ws_d  = (bit_d >= WS_FIRST) && (bit_d <= WS_LAST);
            sdo_d = shift_d[FRAME_W-1];
        end

        push_ok = push && !flush && ((count_q != CNT_FULL) || pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            sck_out      <= 1'b0;
            ws_out       <= 1'b0;
            sdo_out      <= 1'b0;
            tick_out     <= 1'b0;
            underrun_out <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            sck_out      <= sck_d;
            ws_out       <= ws_d;
            sdo_out      <= sdo_d;
            tick_out     <= tick_d;
            underrun_out <= underrun_d;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            fifo_mem[wr_ptr_q] <= audio_in;
        end
    end

endmodule
